// File: rtl/regfile_arb_pkg.sv
// -----------------------------------------------------------------------------
// regfile_arb_pkg
//   Shared constants and helpers for the register-file writeback arbiter.
//   XLEN / REG_AW : default data and register-address widths
//   ZERO_REG      : architectural x0, whose writes are dropped
//   NUM_REQ_MAX   : largest supported requester count (sets pointer width)
//   rr_next()     : next round-robin pointer after an arbitration cycle
// -----------------------------------------------------------------------------
package regfile_arb_pkg;

  localparam int         XLEN        = 32;
  localparam int         REG_AW      = 5;
  localparam logic [4:0] ZERO_REG    = 5'd0;
  localparam int         NUM_REQ_MAX = 8;
  localparam int         PTR_W       = $clog2(NUM_REQ_MAX);

  // The pointer moves to the requester just after the winner, wrapping at
  // num_req; with no winner it stays where it is.
  function automatic logic [PTR_W-1:0] rr_next(
    input logic [PTR_W-1:0] ptr,
    input logic [PTR_W-1:0] grant,
    input logic             any_grant,
    input int               num_req
  );
    if (!any_grant) begin
      return ptr;
    end
    if (int'(grant) >= num_req - 1) begin
      return '0;
    end
    return grant + PTR_W'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin picker.
//   req       in  NUM_REQ  request vector
//   ptr       in  PTR_W    highest-priority requester this cycle
//   grant     out NUM_REQ  one-hot grant (zero when nothing is requested)
//   grant_idx out PTR_W    index of the granted requester (0 when none)
//   any_grant out 1        some requester was granted
// -----------------------------------------------------------------------------
module rr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               any_grant
);

  // Walk the requesters starting at ptr, wrapping past the top, and stop at
  // the first one that is asking. Once any_grant is set, later hits are ignored
  // so the grant stays one-hot.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!any_grant && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = PTR_W'(idx);
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//   Shares the single register-file write port among NUM_REQ writeback
//   requesters with round-robin arbitration and a valid/ready handshake.
//   The winning request is registered onto rf_we/rf_waddr/rf_wdata one cycle
//   after its grant. Writes to x0 are accepted but never raise rf_we.
//
//   Build option: REGFILE_WB_FWD_EN
//     defined   : fwd_dataN bypasses the in-flight write (rf_wdata) when it
//                 targets rd_addrN; rd_addrN == x0 always reads 0.
//     undefined : fwd_dataN = rf_rdataN.
//
//   Ports
//     clk, reset            clock, synchronous active-high reset
//     req_valid/rd/data     per-requester write request (packed by index)
//     req_ready             one-hot grant, zero while reset is high
//     rf_we/waddr/wdata     registered register-file write port
//     stall                 some valid requester was not granted this cycle
//     rd_addr1/2, rf_rdata1/2, fwd_data1/2  read ports and bypassed read data
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = regfile_arb_pkg::XLEN,
  parameter int REG_AW  = regfile_arb_pkg::REG_AW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*REG_AW-1:0] req_rd,
  input  logic [NUM_REQ*XLEN-1:0]  req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rf_we,
  output logic [REG_AW-1:0]        rf_waddr,
  output logic [XLEN-1:0]          rf_wdata,
  output logic                     stall,
  input  logic [REG_AW-1:0]        rd_addr1,
  input  logic [REG_AW-1:0]        rd_addr2,
  input  logic [XLEN-1:0]          rf_rdata1,
  input  logic [XLEN-1:0]          rf_rdata2,
  output logic [XLEN-1:0]          fwd_data1,
  output logic [XLEN-1:0]          fwd_data2
);

  import regfile_arb_pkg::*;

  logic [PTR_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               any_grant;
  logic [REG_AW-1:0]  sel_rd;
  logic [XLEN-1:0]    sel_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // A grant during reset is suppressed, so the requester keeps its request
  // up and re-presents it once reset drops.
  assign req_ready = reset ? '0 : grant;
  assign stall     = reset ? 1'b0 : |(req_valid & ~req_ready);

  assign sel_rd   = req_rd[int'(grant_idx)*REG_AW +: REG_AW];
  assign sel_data = req_data[int'(grant_idx)*XLEN +: XLEN];

  // Pointer and output write register. The address/data registers load on
  // every grant, including x0 grants, but hold when nothing is granted so the
  // last write stays visible on the port.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr   <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (any_grant) begin
      rr_ptr   <= rr_next(rr_ptr, grant_idx, any_grant, NUM_REQ);
      rf_we    <= (sel_rd != REG_AW'(ZERO_REG));
      rf_waddr <= sel_rd;
      rf_wdata <= sel_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

`ifdef REGFILE_WB_FWD_EN
  // The register file still returns the old value while a write is in flight,
  // so a matching read takes the pending write data instead. x0 reads zero.
  always_comb begin
    fwd_data1 = rf_rdata1;
    fwd_data2 = rf_rdata2;
    if (rd_addr1 == REG_AW'(ZERO_REG)) begin
      fwd_data1 = '0;
    end else if (rf_we && (rf_waddr == rd_addr1)) begin
      fwd_data1 = rf_wdata;
    end
    if (rd_addr2 == REG_AW'(ZERO_REG)) begin
      fwd_data2 = '0;
    end else if (rf_we && (rf_waddr == rd_addr2)) begin
      fwd_data2 = rf_wdata;
    end
  end
`else
  assign fwd_data1 = rf_rdata1;
  assign fwd_data2 = rf_rdata2;

  // Read addresses only matter to the bypass; keep the ports without using them.
  logic unused_rd_addr;
  assign unused_rd_addr = ^{rd_addr1, rd_addr2};
`endif

endmodule
